// File: rtl/booth_pkg.sv
// Types and sizing shared by the Booth multiplier core and its operand sequencer,
// so the operand and product widths cannot drift apart.
package booth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int DEFAULT_N        = 9;
    localparam int DEFAULT_MAX_WAIT = 64;

    function automatic int prod_width(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/booth_wdog.sv
// Clearable up-counter that saturates at MAX_WAIT-1 and flags that terminal count.
module booth_wdog #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(MAX_WAIT);
    localparam logic [W-1:0] TC_VAL = W'(MAX_WAIT - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !tc) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = (count_reg == TC_VAL);

endmodule

// File: rtl/booth_op_sequencer.sv
// Feeds an operand pair onto the Booth core's shared bus, waits for completion
// under a watchdog, and presents the captured product over a valid/ready port.
module booth_op_sequencer
    import booth_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic                     mul_start,
    output logic [N-1:0]             mul_data,
    input  logic                     mul_done,
    input  logic [prod_width(N)-1:0] mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_width(N)-1:0] out_product,
    output logic                     timeout_err
);
    localparam int PW = prod_width(N);

    state_t        state_reg;
    state_t        state_next;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [PW-1:0] product_reg;
    logic          timeout_reg;
    logic          accept;
    logic          capture;
    logic          expire;
    logic          wdog_tc;

    booth_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_reg == ST_WAIT),
        .tc    (wdog_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Completion is checked before expiry so a done on the terminal edge still wins.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: state_next = ST_LOAD_B;
            ST_LOAD_B: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mul_done) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end else if (wdog_tc) begin
                    expire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            product_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= expire;
            if (accept) begin
                a_reg <= in_a;
                b_reg <= in_b;
            end
            if (capture) begin
                product_reg <= mul_product;
            end
        end
    end

    always_comb begin
        mul_data = '0;
        case (state_reg)
            ST_LOAD_A:        mul_data = a_reg;
            ST_LOAD_B, ST_WAIT: mul_data = b_reg;
            default:          mul_data = '0;
        endcase
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign mul_start   = (state_reg == ST_LOAD_A);
    assign out_valid   = (state_reg == ST_HOLD);
    assign out_product = product_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Directed bench for booth_op_sequencer with a behavioural multiplier stub of programmable latency.
module tb_booth_op_sequencer;
    import booth_pkg::*;

    localparam int N  = DEFAULT_N;
    localparam int PW = prod_width(N);

    localparam logic [N-1:0]  A1 = N'(-185);
    localparam logic [N-1:0]  B1 = N'(255);
    localparam logic [N-1:0]  A2 = N'(-256);
    localparam logic [N-1:0]  A5 = N'(3);
    localparam logic [N-1:0]  B5 = N'(-4);
    localparam logic [N-1:0]  A6 = N'(7);
    localparam logic [N-1:0]  B6 = N'(-9);
    localparam logic [N-1:0]  B4 = N'(20);
    localparam logic [PW-1:0] P1 = PW'(-47175);
    localparam logic [PW-1:0] P2 = PW'(65536);
    localparam logic [PW-1:0] P4 = PW'(12345);
    localparam logic [PW-1:0] P5 = PW'(-12);
    localparam logic [PW-1:0] P6 = PW'(-63);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic          mul_start;
    logic [N-1:0]  mul_data;
    logic          mul_done;
    logic [PW-1:0] mul_product;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_product;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    // Stub: latches A on the start pulse, B one cycle later, raises done stub_lat cycles after start.
    int                   stub_lat = 20;
    logic                 stub_never = 1'b0;
    int                   stub_cnt;
    logic                 stub_busy;
    logic signed [N-1:0]  stub_a;
    logic signed [N-1:0]  stub_b;
    logic                 stub_done;
    logic [PW-1:0]        stub_prod;
    logic                 force_en = 1'b0;
    logic                 force_done = 1'b0;
    logic [PW-1:0]        force_prod = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt  <= 0;
            stub_busy <= 1'b0;
            stub_a    <= '0;
            stub_b    <= '0;
        end else if (mul_start) begin
            stub_a    <= mul_data;
            stub_cnt  <= 1;
            stub_busy <= 1'b1;
        end else if (stub_busy) begin
            if (stub_cnt == 1) stub_b <= mul_data;
            if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
        end
    end

    assign stub_done   = stub_busy && !stub_never && (stub_cnt >= stub_lat);
    assign stub_prod   = PW'(stub_a) * PW'(stub_b);
    assign mul_done    = force_en ? force_done : stub_done;
    assign mul_product = force_en ? force_prod : stub_prod;

    booth_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_data    (mul_data),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output bit saw_to);
        n      = 0;
        saw_to = 1'b0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (timeout_err === 1'b1) saw_to = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit saw;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_mul_data", mul_data, '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_product", out_product, '0);
        chk("rst_timeout", timeout_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1'b1);
        $display("T0 reset done");

        // Test 1: -185 * 255, consumer always ready
        stub_lat  = 20;
        out_ready = 1'b1;
        send(A1, B1);
        chk("t1_start_k1", mul_start, 1'b1);
        chk("t1_data_a", mul_data, A1);
        chk("t1_in_ready_busy", in_ready, 1'b0);
        tick();
        chk("t1_start_k2", mul_start, 1'b0);
        chk("t1_data_b", mul_data, B1);
        tick();
        chk("t1_start_k3", mul_start, 1'b0);
        chk("t1_data_b_held", mul_data, B1);
        wait_valid(n, saw);
        chk("t1_latency", n, 19);
        chk("t1_product", out_product, P1);
        chk("t1_in_ready_hold", in_ready, 1'b0);
        chk("t1_data_hold", mul_data, '0);
        tick();
        chk("t1_one_valid", out_valid, 1'b0);
        chk("t1_in_ready_after", in_ready, 1'b1);
        $display("T1 product %0d", $signed(out_product));

        // Test 2: -256 * -256 with a 7-cycle downstream stall
        stub_lat  = 10;
        out_ready = 1'b0;
        send(A2, A2);
        tick();
        tick();
        wait_valid(n, saw);
        chk("t2_latency", n, 9);
        for (int i = 0; i < 7; i++) begin
            chk("t2_stall_valid", out_valid, 1'b1);
            chk("t2_stall_product", out_product, P2);
            chk("t2_stall_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = A5;
        in_b      = B5;
        chk("t2_release_in_ready", in_ready, 1'b0);
        chk("t2_release_valid", out_valid, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_after_in_ready", in_ready, 1'b1);
        chk("t2_after_valid", out_valid, 1'b0);
        chk("t2_no_same_cycle_accept", mul_start, 1'b0);
        $display("T2 product %0d", $signed(out_product));

        // Test 3: core never completes
        stub_never = 1'b1;
        send(A5, B5);
        tick();
        tick();
        n   = 0;
        saw = 1'b0;
        while (timeout_err !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (out_valid === 1'b1) saw = 1'b1;
        end
        chk("t3_timeout_cycle", n, 64);
        chk("t3_no_valid", saw, 1'b0);
        chk("t3_in_ready", in_ready, 1'b1);
        chk("t3_product_kept", out_product, P2);
        tick();
        chk("t3_pulse_once", timeout_err, 1'b0);
        stub_never = 1'b0;
        $display("T3 timeout after %0d wait cycles", n);

        // Test 4: spurious done in IDLE and LOAD_B
        force_en   = 1'b1;
        force_done = 1'b1;
        force_prod = PW'(999);
        tick();
        chk("t4_idle_ignore_ready", in_ready, 1'b1);
        chk("t4_idle_ignore_valid", out_valid, 1'b0);
        tick();
        chk("t4_idle_ignore_start", mul_start, 1'b0);
        force_done = 1'b0;
        send(B4, B4);
        tick();
        force_done = 1'b1;
        chk("t4_load_b_data", mul_data, B4);
        tick();
        force_done = 1'b0;
        chk("t4_wait_not_hold", out_valid, 1'b0);
        chk("t4_wait_data", mul_data, B4);
        chk("t4_no_capture", out_product, P2);
        tick();
        tick();
        chk("t4_still_wait", out_valid, 1'b0);
        force_prod = P4;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_product", out_product, P4);
        tick();
        force_en = 1'b0;
        chk("t4_released", in_ready, 1'b1);
        $display("T4 product %0d", $signed(out_product));

        // Test 5: reset during WAIT, then 3 * -4
        stub_lat = 20;
        send(A6, A6);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_in_ready", in_ready, 1'b1);
        chk("t5_rst_data", mul_data, '0);
        chk("t5_rst_start", mul_start, 1'b0);
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_product", out_product, '0);
        chk("t5_rst_timeout", timeout_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        send(A5, B5);
        chk("t5_data_a", mul_data, A5);
        tick();
        chk("t5_data_b", mul_data, B5);
        tick();
        wait_valid(n, saw);
        chk("t5_latency", n, 19);
        chk("t5_product", out_product, P5);
        tick();
        $display("T5 product %0d", $signed(out_product));

        // Test 6: done lands on the watchdog terminal edge
        stub_lat = 65;
        send(A6, B6);
        tick();
        tick();
        wait_valid(n, saw);
        chk("t6_latency", n, 64);
        chk("t6_no_timeout_wait", saw, 1'b0);
        chk("t6_timeout_hold", timeout_err, 1'b0);
        chk("t6_product", out_product, P6);
        tick();
        chk("t6_timeout_after", timeout_err, 1'b0);
        chk("t6_in_ready", in_ready, 1'b1);
        $display("T6 product %0d", $signed(out_product));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
